// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared types and helpers for the LIF neuron array:
//                sweep FSM encoding, saturating add, refractory width.
//  Revision    : 1.0  initial release
// ============================================================================
package lif_pkg;

  // Sweep FSM encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SWEEP_ENC = 2'd1;
  localparam logic [1:0] ST_EMIT_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SWEEP = ST_SWEEP_ENC,
    ST_EMIT  = ST_EMIT_ENC
  } state_e;

  // Bits needed to hold a refractory count of 0..refrac; never less than 1
  function automatic int refrac_width(input int refrac);
    int w;
    w = $clog2(refrac + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // Adds two sign-extended operands and clamps the result to the signed
  // range of a 'width'-bit register (width <= 31)
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -hi - 33'sd1;
    if (s > hi) return hi[31:0];
    if (s < lo) return lo[31:0];
    return s[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_if.sv
`default_nettype none
// ============================================================================
//  Module      : lif_if
//  Description : Event-in / spike-out bus of the LIF neuron array, plus the
//                timestep tick and status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface lif_if #(
  parameter int IDX_W   = 3,
  parameter int W_WIDTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IDX_W-1:0]          in_idx;
  logic signed [W_WIDTH-1:0] in_weight;
  logic                      tick;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_W-1:0]          out_idx;
  logic                      tick_overrun;

  // Router / motor layer side
  modport master (
    output in_valid, in_idx, in_weight, tick, out_ready,
    input  in_ready, busy, out_valid, out_idx, tick_overrun
  );

  // Neuron array side
  modport slave (
    input  in_valid, in_idx, in_weight, tick, out_ready,
    output in_ready, busy, out_valid, out_idx, tick_overrun
  );
endinterface
`default_nettype wire

// File: rtl/lif_neuron_array_update.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update
//  Description : Combinational per-neuron timestep update: refractory
//                countdown, leak, threshold compare and reset on fire.
//                One instance is time-shared across the whole array.
//  Revision    : 1.0  initial release
// ============================================================================
module lif_update #(
  parameter int V_WIDTH    = 16,
  parameter int R_W        = 2,
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = 1000,
  parameter int V_RESET    = 0,
  parameter int REFRAC     = 2
) (
  input  logic signed [V_WIDTH-1:0] v,
  input  logic [R_W-1:0]            refrac,
  output logic signed [V_WIDTH-1:0] v_next,
  output logic [R_W-1:0]            refrac_next,
  output logic                      fire
);

  localparam logic signed [V_WIDTH-1:0] c_th     = V_WIDTH'(V_TH);
  localparam logic signed [V_WIDTH-1:0] c_v_rst  = V_WIDTH'(V_RESET);
  localparam logic [R_W-1:0]            c_refrac = R_W'(REFRAC);

  logic signed [V_WIDTH-1:0] v_leak;

  // Leak moves v toward zero by v>>>LEAK_SHIFT, so it can never overflow;
  // a refractory neuron only counts down and keeps its membrane value
  always_comb begin
    v_leak      = v - (v >>> LEAK_SHIFT);
    v_next      = v;
    refrac_next = refrac;
    fire        = 1'b0;
    if (refrac != '0) begin
      refrac_next = refrac - R_W'(1);
    end else if (v_leak >= c_th) begin
      v_next      = c_v_rst;
      refrac_next = c_refrac;
      fire        = 1'b1;
    end else begin
      v_next = v_leak;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array
//  Description : Time-multiplexed array of leaky integrate-and-fire neurons.
//                Input events integrate while idle; each tick sweeps all
//                neurons through the shared update datapath and emits an
//                indexed spike for every neuron that fires.
//  Revision    : 1.0  initial release
// ============================================================================
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 8,
  parameter int IDX_W      = 3,
  parameter int V_WIDTH    = 16,
  parameter int W_WIDTH    = 8,
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = 1000,
  parameter int V_RESET    = 0,
  parameter int REFRAC     = 2
) (
  input logic  clk,
  input logic  reset,
  lif_if.slave bus
);

  localparam int                        R_W     = refrac_width(REFRAC);
  localparam logic [IDX_W-1:0]          c_last  = IDX_W'(N_NEURONS - 1);
  localparam logic signed [V_WIDTH-1:0] c_v_rst = V_WIDTH'(V_RESET);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;
  logic                      tick_pending_q, tick_pending_d;
  logic                      tick_overrun_q, tick_overrun_d;
  logic signed [V_WIDTH-1:0] v_q [N_NEURONS];
  logic signed [V_WIDTH-1:0] v_d [N_NEURONS];
  logic [R_W-1:0]            refrac_q [N_NEURONS];
  logic [R_W-1:0]            refrac_d [N_NEURONS];

  logic                      in_ready_w;
  logic                      busy_w;
  logic                      idx_ok;
  logic                      sweep_done;
  logic signed [V_WIDTH-1:0] upd_v;
  logic [R_W-1:0]            upd_refrac;
  logic                      upd_fire;

  assign busy_w     = (state_q != ST_IDLE);
  assign in_ready_w = (state_q == ST_IDLE) && !reset;
  assign idx_ok     = (32'(bus.in_idx) < N_NEURONS);

  assign bus.in_ready     = in_ready_w;
  assign bus.busy         = busy_w;
  assign bus.out_valid    = (state_q == ST_EMIT);
  assign bus.out_idx      = out_idx_q;
  assign bus.tick_overrun = tick_overrun_q;

  lif_update #(
    .V_WIDTH    (V_WIDTH),
    .R_W        (R_W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .V_TH       (V_TH),
    .V_RESET    (V_RESET),
    .REFRAC     (REFRAC)
  ) u_update (
    .v           (v_q[ptr_q]),
    .refrac      (refrac_q[ptr_q]),
    .v_next      (upd_v),
    .refrac_next (upd_refrac),
    .fire        (upd_fire)
  );

  // Next-state: integrate events while idle, step the sweep pointer,
  // hold in EMIT until the spike is taken, chain a pending tick
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_idx_d  = out_idx_q;
    v_d        = v_q;
    refrac_d   = refrac_q;
    sweep_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Events into a refractory neuron or past the array are consumed
        if (bus.in_valid && in_ready_w && idx_ok && (refrac_q[bus.in_idx] == '0)) begin
          v_d[bus.in_idx] = V_WIDTH'(sat_add(32'(v_q[bus.in_idx]),
                                             32'(bus.in_weight), V_WIDTH));
        end
        if (bus.tick) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        v_d[ptr_q]      = upd_v;
        refrac_d[ptr_q] = upd_refrac;
        if (upd_fire) begin
          state_d   = ST_EMIT;
          out_idx_d = ptr_q;
        end else if (ptr_q == c_last) begin
          sweep_done = 1'b1;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_EMIT: begin
        if (bus.out_ready) begin
          if (ptr_q == c_last) begin
            sweep_done = 1'b1;
          end else begin
            state_d = ST_SWEEP;
            ptr_d   = ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending tick restarts the sweep straight away, skipping IDLE
    if (sweep_done) begin
      ptr_d   = '0;
      state_d = tick_pending_q ? ST_SWEEP : ST_IDLE;
    end

    // One tick may queue behind a running sweep; a second one is lost
    tick_pending_d = (tick_pending_q && !sweep_done) || (bus.tick && busy_w);
    tick_overrun_d = tick_overrun_q ||
                     (bus.tick && busy_w && tick_pending_q && !sweep_done);
  end

  // State and neuron registers; reset aborts any sweep and pending spike
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      out_idx_q      <= '0;
      tick_pending_q <= 1'b0;
      tick_overrun_q <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_q[k]      <= c_v_rst;
        refrac_q[k] <= '0;
      end
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      out_idx_q      <= out_idx_d;
      tick_pending_q <= tick_pending_d;
      tick_overrun_q <= tick_overrun_d;
      v_q            <= v_d;
      refrac_q       <= refrac_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron_array
//  Description : Self-checking bench for lif_neuron_array. A behavioural
//                neuron model predicts membrane values and spike order;
//                expected spikes are queued at tick time and popped when
//                the DUT hands them over.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lif_neuron_array;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lif_if #(.IDX_W(3), .W_WIDTH(8)) bus ();

  lif_neuron_array #(
    .N_NEURONS (8), .IDX_W (3), .V_WIDTH (16), .W_WIDTH (8),
    .LEAK_SHIFT(4), .V_TH (1000), .V_RESET (0), .REFRAC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int w;
    int exp_v;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int mv [8];
  int mr [8];
  int exp_q [$];
  int mon_exp;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin mv[k] = 0; mr[k] = 0; end
    exp_q.delete();
  endfunction

  function automatic void model_event(input int idx, input int w);
    int s;
    if (idx < 8 && mr[idx] == 0) begin
      s = mv[idx] + w;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      mv[idx] = s;
    end
  endfunction

  function automatic void model_sweep();
    int vl;
    for (int k = 0; k < 8; k++) begin
      if (mr[k] > 0) mr[k] = mr[k] - 1;
      else begin
        vl = mv[k] - (mv[k] >>> 4);
        if (vl >= 1000) begin mv[k] = 0; mr[k] = 2; exp_q.push_back(k); end
        else mv[k] = vl;
      end
    end
  endfunction

  function automatic int dut_v(input int k);
    return int'(dut.v_q[k]);
  endfunction

  task automatic check_all_v(input string tag);
    for (int k = 0; k < 8; k++) check($sformatf("%s_v%0d", tag, k), dut_v(k), mv[k]);
  endtask

  // ---------------- spike scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("spike_unexpected", int'(bus.out_idx), -1);
      else begin
        mon_exp = exp_q.pop_front();
        check("spike_idx", int'(bus.out_idx), mon_exp);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic send_event(input int idx, input int w);
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_idx    = 3'(idx);
    bus.in_weight = 8'(w);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (done) model_event(idx, w);
    else check("event_accept_timeout", 0, 1);
  endtask

  // Tick from IDLE and wait for the sweep to finish (out_ready assumed high)
  task automatic do_tick(output int busy_cycles, output int ready_hi);
    bus.tick = 1'b1;
    model_sweep();
    @(posedge clk); #1;
    bus.tick = 1'b0;
    busy_cycles = 0;
    ready_hi = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.busy) break;
      busy_cycles++;
      if (bus.in_ready) ready_hi++;
    end
    check("sweep_finished", int'(busy_cycles < 200), 1);
    @(posedge clk); #1;
    check("spikes_drained", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   bc, rh, gap, seen_idle, waited;
    bit   held;
    vec_t vecs [6];

    vecs[0] = '{0,  100,  100};
    vecs[1] = '{0,   60,  160};
    vecs[2] = '{1, -128, -128};
    vecs[3] = '{2,  127,  127};
    vecs[4] = '{2,   -5,  122};
    vecs[5] = '{7,   -1,   -1};

    bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_weight = '0;
    bus.tick = 1'b0; bus.out_ready = 1'b1;
    reset = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",     int'(bus.in_ready), 0);
    check("rst_busy",         int'(bus.busy), 0);
    check("rst_out_valid",    int'(bus.out_valid), 0);
    check("rst_out_idx",      int'(bus.out_idx), 0);
    check("rst_tick_overrun", int'(bus.tick_overrun), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    check_all_v("rst");

    // Empty sweep: exactly N busy cycles, in_ready low throughout
    do_tick(bc, rh);
    check("t1_busy_cycles", bc, 8);
    check("t1_ready_low", rh, 0);

    // Table-driven integration
    for (int i = 0; i < 6; i++) begin
      send_event(vecs[i].idx, vecs[i].w);
      check($sformatf("vec%0d_v", i), dut_v(vecs[i].idx), vecs[i].exp_v);
    end

    // Leak below threshold, positive and negative
    do_tick(bc, rh);
    check("t3_v0_first", dut_v(0), 150);
    check("t3_v1_neg", dut_v(1), -120);
    check("t3_v7_to_zero", dut_v(7), 0);
    do_tick(bc, rh);
    check("t3_v0_second", dut_v(0), 141);
    check_all_v("t3");

    // Single spike from neuron 3
    do_reset();
    for (int i = 0; i < 9; i++) send_event(3, 127);
    check("t2_v3_pre", dut_v(3), 1143);
    do_tick(bc, rh);
    check("t2_busy_cycles", bc, 9);
    check("t2_v3_post", dut_v(3), 0);

    // Refractory drops events for two ticks
    send_event(3, 127);
    check("t4_refrac_a", dut_v(3), 0);
    do_tick(bc, rh);
    send_event(3, 127);
    check("t4_refrac_b", dut_v(3), 0);
    do_tick(bc, rh);
    send_event(3, 127);
    check("t4_integrates", dut_v(3), 127);

    // Back-pressure on the spike stream
    do_reset();
    for (int i = 0; i < 9; i++) send_event(1, 127);
    for (int i = 0; i < 9; i++) send_event(5, 127);
    bus.out_ready = 1'b0;
    bus.tick = 1'b1;
    model_sweep();
    @(posedge clk); #1 bus.tick = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 50) begin @(posedge clk); #1; waited++; end
    check("t5_out_valid_seen", int'(bus.out_valid), 1);
    held = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!(bus.out_valid && bus.out_idx == 3'd1 && bus.busy)) held = 1'b0;
    end
    check("t5_hold_idx1", int'(held), 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    waited = 0;
    while (bus.busy && waited < 50) begin @(posedge clk); #1; waited++; end
    check("t5_sweep_ends", int'(bus.busy), 0);
    check("t5_drained", exp_q.size(), 0);
    check_all_v("t5");

    // Reset while a spike is waiting
    for (int i = 0; i < 9; i++) send_event(0, 127);
    bus.out_ready = 1'b0;
    bus.tick = 1'b1;
    model_sweep();
    @(posedge clk); #1 bus.tick = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 50) begin @(posedge clk); #1; waited++; end
    check("t7_out_valid_seen", int'(bus.out_valid), 1);
    do_reset();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t7_out_valid_dropped", int'(bus.out_valid), 0);
    check("t7_busy_cleared", int'(bus.busy), 0);
    check("t7_in_ready", int'(bus.in_ready), 1);
    check("t7_v0_reset", dut_v(0), 0);
    @(posedge clk); #1;

    // Saturation both ways
    for (int i = 0; i < 300; i++) send_event(4, 127);
    check("t6_sat_max", dut_v(4), 32767);
    for (int i = 0; i < 300; i++) send_event(6, -128);
    check("t6_sat_min", dut_v(6), -32768);

    // Tick while busy chains a second sweep; a third tick overruns
    bus.tick = 1'b1;
    model_sweep();
    model_sweep();
    @(posedge clk); #1 bus.tick = 1'b0;
    bc = 0; gap = 0; seen_idle = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy) begin bc++; if (seen_idle != 0) gap = 1; end
      else seen_idle = 1;
      if (c == 2) check("t6_no_overrun_yet", int'(bus.tick_overrun), 0);
      bus.tick = (c == 2 || c == 5);
    end
    bus.tick = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_cycles", bc, 17);
    check("t6_no_idle_gap", gap, 0);
    check("t6_overrun", int'(bus.tick_overrun), 1);
    check("t6_drained", exp_q.size(), 0);
    check_all_v("t6");

    do_reset();
    @(negedge clk);
    check("t6_overrun_cleared", int'(bus.tick_overrun), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
